apb_rom_streamer: RTL and testbench

APB3 master that sits directly upstream of apb_rom and drives its slave port. On a start pulse it performs a burst of single-word APB3 reads across a programmable address range and pushes each returned word onto an AXI-Stream-style output. The last word is marked with tlast. It is used to copy boot or coefficient images out of the ROM into downstream stream consumers.

---
 rtl/apb_rom_streamer.sv | 154 +++++++++++++++
 tb/tb_apb_rom_streamer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rom_streamer.sv
// APB3 read-burst master that streams ROM words out as AXI-Stream beats.
// Optional ACCESS-phase timeout is enabled by defining APB_STREAMER_TIMEOUT_EN.
module apb_rom_streamer #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [COUNT_WIDTH-1:0]   num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] m_apb_paddr,
    output logic                     m_apb_psel,
    output logic                     m_apb_penable,
    output logic                     m_apb_pwrite,
    output logic [BUS_WIDTH*8-1:0]   m_apb_pwdata,
    input  logic                     m_apb_pready,
    input  logic [BUS_WIDTH*8-1:0]   m_apb_prdata,
    input  logic                     m_apb_pslverror,
    output logic [BUS_WIDTH*8-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast
);

    localparam int DW = BUS_WIDTH * 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_PUSH   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]            tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic                     error_q, error_d;

`ifdef APB_STREAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        error_d  = error_q;
`ifdef APB_STREAMER_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    cnt_d   = num_words;
                    error_d = 1'b0;
                    state_d = (num_words == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef APB_STREAMER_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_apb_pready) begin
                    if (m_apb_pslverror) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        tdata_d  = m_apb_prdata;
                        tvalid_d = 1'b1;
                        tlast_d  = (cnt_q == COUNT_WIDTH'(1));
                        state_d  = S_PUSH;
                    end
                end
`ifdef APB_STREAMER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_PUSH: begin
                // tvalid is registered, so a handshake can only land here
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_q - COUNT_WIDTH'(1);
                    addr_d   = addr_q + ADDRESS_WIDTH'(BUS_WIDTH);
                    state_d  = (cnt_q != COUNT_WIDTH'(1)) ? S_SETUP : S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            error_q  <= error_d;
        end
    end

`ifdef APB_STREAMER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    assign m_apb_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign m_apb_penable = (state_q == S_ACCESS);
    assign m_apb_paddr   = addr_q;
    assign m_apb_pwrite  = 1'b0;
    assign m_apb_pwdata  = '0;
    assign busy          = m_apb_psel || (state_q == S_PUSH);
    assign done          = (state_q == S_FINISH);
    assign error         = error_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_apb_rom_streamer.sv
// Directed bench for apb_rom_streamer with a combinational APB ROM model.
module tb_apb_rom_streamer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] num_words = '0;
    logic        busy, done, error;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata, tdata;
    logic        pready, pslverror;
    logic        tvalid, tlast;
    logic        tready = 1'b1;

    logic        rdy = 1'b1;
    logic        err_en = 1'b0;
    logic [15:0] err_addr = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign pready    = rdy;
    assign prdata    = {~paddr, paddr};
    assign pslverror = err_en && (paddr == err_addr);

    apb_rom_streamer #(
        .ADDRESS_WIDTH(16),
        .BUS_WIDTH(4),
        .COUNT_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .start_addr(start_addr),
        .num_words(num_words),
        .busy(busy),
        .done(done),
        .error(error),
        .m_apb_paddr(paddr),
        .m_apb_psel(psel),
        .m_apb_penable(penable),
        .m_apb_pwrite(pwrite),
        .m_apb_pwdata(pwdata),
        .m_apb_pready(pready),
        .m_apb_prdata(prdata),
        .m_apb_pslverror(pslverror),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast)
    );

    // Inputs change 1ns after posedge, so negedge sees what the next edge sees
    logic [15:0] q_addr[$];
    logic [32:0] q_beat[$];
    int          done_cnt = 0;
    int          psel_cnt = 0;
    int          acc_cnt = 0;
    int          unstable = 0;
    int          overlap = 0;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic [32:0] prev_b = '0;

    always @(negedge clk) begin
        if (psel && penable && pready) q_addr.push_back(paddr);
        if (psel && penable) acc_cnt++;
        if (psel) psel_cnt++;
        if (done) done_cnt++;
        if (tvalid && tready) q_beat.push_back({tlast, tdata});
        if (tvalid && prev_v && !prev_hs && ({tlast, tdata} != prev_b)) unstable++;
        if (tvalid && psel) overlap++;
        prev_v  = tvalid;
        prev_hs = tvalid && tready;
        prev_b  = {tlast, tdata};
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] beat(input logic [15:0] a, input logic l);
        return {l, ~a, a};
    endfunction

    task automatic pulse_start(input logic [15:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = a;
        num_words = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int maxc);
        int c = 0;
        while (done_cnt == d0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, p0, a0;
        logic [15:0] exp_a[4];

        // reset state
        #12;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_busy_done_err", 64'({busy, done, error}), 64'd0);
        chk("rst_stream", 64'({tvalid, tlast, tdata}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // basic burst
        q_addr.delete(); q_beat.delete();
        d0 = done_cnt;
        pulse_start(16'h0000, 16'd4);
        chk("basic_busy", 64'(busy), 64'd1);
        wait_done("basic_done", d0, 40);
        chk("basic_nacc", 64'(q_addr.size()), 64'd4);
        chk("basic_nbeat", 64'(q_beat.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_addr.size()) chk("basic_addr", 64'(q_addr[i]), 64'(4 * i));
            if (i < q_beat.size())
                chk("basic_beat", 64'(q_beat[i]), 64'(beat(16'(4 * i), i == 3)));
        end
        chk("basic_err", 64'(error), 64'd0);
        chk("basic_pwrite_pwdata", 64'({pwrite, pwdata}), 64'd0);

        // zero length
        q_beat.delete();
        p0 = psel_cnt; d0 = done_cnt;
        pulse_start(16'h0100, 16'd0);
        chk("zero_done_now", 64'({done, busy}), 64'b10);
        @(posedge clk); #1;
        chk("zero_done_drop", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("zero_done_once", 64'(done_cnt - d0), 64'd1);
        chk("zero_no_psel", 64'(psel_cnt - p0), 64'd0);
        chk("zero_no_beat", 64'(q_beat.size()), 64'd0);

        // backpressure
        q_beat.delete();
        unstable = 0; overlap = 0;
        tready = 1'b0;
        d0 = done_cnt;
        pulse_start(16'h0020, 16'd3);
        for (int i = 0; i < 3; i++) begin
            int c = 0;
            while (!tvalid && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk("bp_tvalid", 64'(tvalid), 64'd1);
            repeat (10) @(negedge clk);
            chk("bp_hold", 64'({tlast, tdata}),
                64'(beat(16'(16'h20 + 4 * i), i == 2)));
            @(posedge clk); #1;
            tready = 1'b1;
            @(posedge clk); #1;
            tready = 1'b0;
        end
        wait_done("bp_done", d0, 20);
        tready = 1'b1;
        chk("bp_nbeat", 64'(q_beat.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < q_beat.size())
                chk("bp_order", 64'(q_beat[i]),
                    64'(beat(16'(16'h20 + 4 * i), i == 2)));
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_no_setup_in_push", 64'(overlap), 64'd0);

        // slave error on the 3rd access
        q_beat.delete();
        err_en = 1'b1;
        err_addr = 16'h0048;
        d0 = done_cnt;
        pulse_start(16'h0040, 16'd5);
        wait_done("serr_done", d0, 40);
        chk("serr_nbeat", 64'(q_beat.size()), 64'd2);
        chk("serr_error", 64'(error), 64'd1);
        chk("serr_idle", 64'({busy, psel, tvalid}), 64'd0);
        err_en = 1'b0;
        d0 = done_cnt;
        pulse_start(16'h0000, 16'd1);
        chk("serr_clear", 64'(error), 64'd0);
        wait_done("serr_next_done", d0, 20);

        // address wrap with an ignored mid-burst start
        q_addr.delete(); q_beat.delete();
        d0 = done_cnt;
        pulse_start(16'hFFF8, 16'd4);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = 16'h1234;
        num_words = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("wrap_done", d0, 40);
        exp_a = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        chk("wrap_nacc", 64'(q_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < q_addr.size()) chk("wrap_addr", 64'(q_addr[i]), 64'(exp_a[i]));
        chk("wrap_nbeat", 64'(q_beat.size()), 64'd4);
        if (q_beat.size() == 4)
            chk("wrap_last", 64'(q_beat[3]), 64'(beat(16'h0004, 1'b1)));
        p0 = psel_cnt;
        repeat (8) @(negedge clk);
        chk("wrap_start_ignored", 64'(psel_cnt - p0), 64'd0);

        // reset mid-burst, during ACCESS
        rdy = 1'b0;
        d0 = done_cnt;
        pulse_start(16'h0080, 16'd2);
        @(posedge clk); #2;
        chk("mrst_in_access", 64'({psel, penable}), 64'b11);
        rstn = 1'b0;
        #1;
        chk("mrst_apb", 64'({psel, penable, paddr}), 64'd0);
        chk("mrst_flags", 64'({busy, done, error, tvalid, tlast}), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        q_addr.delete(); q_beat.delete();
        d0 = done_cnt;
        pulse_start(16'h0010, 16'd2);
        wait_done("mrst_fresh_done", d0, 30);
        chk("mrst_fresh_nacc", 64'(q_addr.size()), 64'd2);
        if (q_beat.size() == 2) begin
            chk("mrst_fresh_b0", 64'(q_beat[0]), 64'(beat(16'h0010, 1'b0)));
            chk("mrst_fresh_b1", 64'(q_beat[1]), 64'(beat(16'h0014, 1'b1)));
        end else begin
            chk("mrst_fresh_nbeat", 64'(q_beat.size()), 64'd2);
        end

`ifdef APB_STREAMER_TIMEOUT_EN
        q_beat.delete();
        rdy = 1'b0;
        a0 = acc_cnt; d0 = done_cnt;
        pulse_start(16'h0200, 16'd1);
        wait_done("tmo_done", d0, 40);
        chk("tmo_access_cycles", 64'(acc_cnt - a0), 64'd8);
        chk("tmo_error", 64'(error), 64'd1);
        chk("tmo_no_beat", 64'(q_beat.size()), 64'd0);
        rdy = 1'b1;
`else
        a0 = acc_cnt;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
